// File: rtl/csi_phy_ctrl.sv
// D-PHY PPI / CSI datapath sequencer: power-up, lane sync skew check, HS burst watchdog, forcerxmode recovery.
// Optional statistics outputs (recover_count, skew_err_count) are built when CSI_PHY_STATS_EN is defined.
module csi_phy_ctrl #(
  parameter int unsigned N_DATA_LANES   = 2,
  parameter int unsigned STARTUP_CYCLES = 256,
  parameter int unsigned SKEW_WINDOW    = 4,
  parameter int unsigned HS_TIMEOUT     = 65535,
  parameter int unsigned FORCE_CYCLES   = 16
) (
  input  logic                    rxbyteclkhs,
  input  logic                    rxbyteclkhs_resetn,
  input  logic                    ctrl_enable,
  input  logic                    cl_stopstate,
  input  logic [N_DATA_LANES-1:0] dl_rxactivehs,
  input  logic [N_DATA_LANES-1:0] dl_rxsynchs,
  output logic                    cl_enable,
  output logic [N_DATA_LANES-1:0] dl_enable,
  output logic [N_DATA_LANES-1:0] dl_forcerxmode,
  output logic                    datapath_resetn,
  output logic                    phy_ready,
  output logic [2:0]              ctrl_state,
  output logic                    err_skew,
  output logic                    err_timeout
`ifdef CSI_PHY_STATS_EN
  ,
  output logic [15:0]             recover_count,
  output logic [15:0]             skew_err_count
`endif
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STARTUP = 3'd1,
    S_IDLE    = 3'd2,
    S_SYNC    = 3'd3,
    S_RX      = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  localparam logic [15:0] ST_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [3:0]  SKEW_W  = 4'(SKEW_WINDOW);
  localparam logic [15:0] HS_TO   = 16'(HS_TIMEOUT);
  localparam logic [7:0]  FRC_N   = 8'(FORCE_CYCLES);

  state_t                  state_q;
  logic                    cl_en_q;
  logic [N_DATA_LANES-1:0] dl_en_q;
  logic [N_DATA_LANES-1:0] dl_force_q;
  logic                    dp_rstn_q;
  logic                    ready_q;
  logic                    err_skew_q;
  logic                    err_to_q;
  logic [15:0]             st_cnt_q;
  logic [3:0]              skew_q;
  logic [15:0]             to_q;
  logic [7:0]              frc_cnt_q;
  logic [N_DATA_LANES-1:0] mask_q;
`ifdef CSI_PHY_STATS_EN
  logic [15:0]             rec_cnt_q;
  logic [15:0]             skew_cnt_q;
`endif

  logic [15:0]             st_inc;
  logic [3:0]              skew_inc;
  logic [15:0]             to_inc;
  logic [7:0]              frc_inc;
  logic [N_DATA_LANES-1:0] mask_now;
  logic                    any_active;
  logic                    sync_ok;
  logic                    skew_fail;
  logic                    to_fail;

  // Saturating increments; skew/timeout limits are judged on the post-increment count.
  always_comb begin
    st_inc     = (st_cnt_q  == '1) ? st_cnt_q  : st_cnt_q  + 16'd1;
    skew_inc   = (skew_q    == '1) ? skew_q    : skew_q    + 4'd1;
    to_inc     = (to_q      == '1) ? to_q      : to_q      + 16'd1;
    frc_inc    = (frc_cnt_q == '1) ? frc_cnt_q : frc_cnt_q + 8'd1;
    mask_now   = mask_q | dl_rxsynchs;
    any_active = |dl_rxactivehs;
    sync_ok    = (&mask_now) && (skew_inc < SKEW_W);
    skew_fail  = (state_q == S_SYNC) && !sync_ok && ((skew_inc >= SKEW_W) || !any_active);
    to_fail    = (state_q == S_RX) && any_active && (to_inc == HS_TO);
  end

  always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_resetn) begin
    if (!rxbyteclkhs_resetn) begin
      state_q    <= S_OFF;
      cl_en_q    <= 1'b0;
      dl_en_q    <= '0;
      dl_force_q <= '0;
      dp_rstn_q  <= 1'b0;
      ready_q    <= 1'b0;
      err_skew_q <= 1'b0;
      err_to_q   <= 1'b0;
      st_cnt_q   <= '0;
      skew_q     <= '0;
      to_q       <= '0;
      frc_cnt_q  <= '0;
      mask_q     <= '0;
`ifdef CSI_PHY_STATS_EN
      rec_cnt_q  <= '0;
      skew_cnt_q <= '0;
`endif
    end else if (!ctrl_enable) begin
      // Same as reset, but statistics are held.
      state_q    <= S_OFF;
      cl_en_q    <= 1'b0;
      dl_en_q    <= '0;
      dl_force_q <= '0;
      dp_rstn_q  <= 1'b0;
      ready_q    <= 1'b0;
      err_skew_q <= 1'b0;
      err_to_q   <= 1'b0;
      st_cnt_q   <= '0;
      skew_q     <= '0;
      to_q       <= '0;
      frc_cnt_q  <= '0;
      mask_q     <= '0;
    end else begin
      err_skew_q <= skew_fail;
      err_to_q   <= to_fail;
`ifdef CSI_PHY_STATS_EN
      if ((skew_fail || to_fail) && rec_cnt_q != '1) rec_cnt_q <= rec_cnt_q + 16'd1;
      if (skew_fail && skew_cnt_q != '1) skew_cnt_q <= skew_cnt_q + 16'd1;
`endif
      if (skew_fail || to_fail) begin
        state_q    <= S_RECOVER;
        dl_force_q <= '1;
        dp_rstn_q  <= 1'b0;
        ready_q    <= 1'b0;
        frc_cnt_q  <= '0;
      end
      case (state_q)
        S_OFF: begin
          state_q  <= S_STARTUP;
          cl_en_q  <= 1'b1;
          dl_en_q  <= '1;
          st_cnt_q <= '0;
        end
        S_STARTUP: begin
          if (!cl_stopstate) begin
            st_cnt_q <= '0;
          end else begin
            st_cnt_q <= st_inc;
            if (st_cnt_q == ST_LAST) begin
              state_q   <= S_IDLE;
              dp_rstn_q <= 1'b1;
              ready_q   <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (|dl_rxsynchs) begin
            mask_q <= dl_rxsynchs;
            skew_q <= '0;
            to_q   <= '0;
            state_q <= (&dl_rxsynchs) ? S_RX : S_SYNC;
          end
        end
        S_SYNC: begin
          mask_q <= mask_now;
          skew_q <= skew_inc;
          if (sync_ok) begin
            state_q <= S_RX;
            to_q    <= '0;
          end
        end
        S_RX: begin
          if (!any_active) state_q <= S_IDLE;
          else if (!to_fail) to_q <= to_inc;
        end
        S_RECOVER: begin
          frc_cnt_q <= frc_inc;
          if (frc_inc == FRC_N) begin
            state_q    <= S_STARTUP;
            dl_force_q <= '0;
            st_cnt_q   <= '0;
          end
        end
        default: state_q <= S_OFF;
      endcase
    end
  end

  assign cl_enable       = cl_en_q;
  assign dl_enable       = dl_en_q;
  assign dl_forcerxmode  = dl_force_q;
  assign datapath_resetn = dp_rstn_q;
  assign phy_ready       = ready_q;
  assign ctrl_state      = state_q;
  assign err_skew        = err_skew_q;
  assign err_timeout     = err_to_q;
`ifdef CSI_PHY_STATS_EN
  assign recover_count   = rec_cnt_q;
  assign skew_err_count  = skew_cnt_q;
`endif

endmodule

// File: tb/tb_csi_phy_ctrl.sv
// Directed bench for csi_phy_ctrl (2 lanes, HS_TIMEOUT=100); stats checks build with CSI_PHY_STATS_EN.
module tb_csi_phy_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       stop;
  logic [1:0] act;
  logic [1:0] syn;

  logic       cl_enable;
  logic [1:0] dl_enable;
  logic [1:0] dl_forcerxmode;
  logic       datapath_resetn;
  logic       phy_ready;
  logic [2:0] ctrl_state;
  logic       err_skew;
  logic       err_timeout;
`ifdef CSI_PHY_STATS_EN
  logic [15:0] recover_count;
  logic [15:0] skew_err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csi_phy_ctrl #(
    .N_DATA_LANES  (2),
    .STARTUP_CYCLES(256),
    .SKEW_WINDOW   (4),
    .HS_TIMEOUT    (100),
    .FORCE_CYCLES  (16)
  ) dut (
    .rxbyteclkhs       (clk),
    .rxbyteclkhs_resetn(rst_n),
    .ctrl_enable       (en),
    .cl_stopstate      (stop),
    .dl_rxactivehs     (act),
    .dl_rxsynchs       (syn),
    .cl_enable         (cl_enable),
    .dl_enable         (dl_enable),
    .dl_forcerxmode    (dl_forcerxmode),
    .datapath_resetn   (datapath_resetn),
    .phy_ready         (phy_ready),
    .ctrl_state        (ctrl_state),
    .err_skew          (err_skew),
    .err_timeout       (err_timeout)
`ifdef CSI_PHY_STATS_EN
    ,
    .recover_count     (recover_count),
    .skew_err_count    (skew_err_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_startup(input string tag);
    stop = 1'b1;
    tick(255);
    check({tag, "_st_pre"}, 32'(ctrl_state), 32'd1);
    tick();
    check({tag, "_st_idle"}, 32'(ctrl_state), 32'd2);
    check({tag, "_ready"}, 32'(phy_ready), 32'd1);
  endtask

  task automatic run_recover(input string tag);
    tick();
    check({tag, "_pulse_end"}, 32'({err_skew, err_timeout}), 32'd0);
    tick(14);
    check({tag, "_rec_last"}, 32'(ctrl_state), 32'd5);
    check({tag, "_frc_last"}, 32'(dl_forcerxmode), 32'd3);
    tick();
    check({tag, "_to_start"}, 32'(ctrl_state), 32'd1);
    check({tag, "_frc_off"}, 32'(dl_forcerxmode), 32'd0);
    check({tag, "_dp_rst"}, 32'(datapath_resetn), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; stop = 1'b0; act = 2'b00; syn = 2'b00;
    tick(3);
    check("rst_state", 32'(ctrl_state), 32'd0);
    check("rst_en", 32'({cl_enable, dl_enable}), 32'd0);
    check("rst_outs", 32'({dl_forcerxmode, datapath_resetn, phy_ready, err_skew, err_timeout}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Power-up: enables the cycle after enable, ready 257 cycles after.
    en = 1'b1; stop = 1'b1;
    tick();
    check("t1_state", 32'(ctrl_state), 32'd1);
    check("t1_en", 32'({cl_enable, dl_enable}), 32'h7);
    check("t1_notready", 32'(phy_ready), 32'd0);
    tick(255);
    check("t1_st256", 32'(ctrl_state), 32'd1);
    tick();
    check("t1_idle", 32'(ctrl_state), 32'd2);
    check("t1_ready", 32'({phy_ready, datapath_resetn}), 32'h3);

    // Skew within window: lane1 three cycles after lane0.
    act = 2'b11; syn = 2'b01;
    tick();
    check("t3a_sync", 32'(ctrl_state), 32'd3);
    syn = 2'b00;
    tick(2);
    check("t3a_still", 32'(ctrl_state), 32'd3);
    syn = 2'b10;
    tick();
    check("t3a_rx", 32'(ctrl_state), 32'd4);
    check("t3a_noerr", 32'(err_skew), 32'd0);
    syn = 2'b00;

    // Burst ends at RX cycle 50.
    tick(49);
    check("t4b_rx49", 32'(ctrl_state), 32'd4);
    act = 2'b00;
    tick();
    check("t4b_idle", 32'(ctrl_state), 32'd2);
    check("t4b_noerr", 32'(err_timeout), 32'd0);

    // Simultaneous sync goes straight to RX, then times out after 100 cycles.
    act = 2'b11; syn = 2'b11;
    tick();
    check("t4a_rx", 32'(ctrl_state), 32'd4);
    syn = 2'b00;
    tick(99);
    check("t4a_rx99", 32'(ctrl_state), 32'd4);
    check("t4a_noerr99", 32'(err_timeout), 32'd0);
    tick();
    check("t4a_err", 32'(err_timeout), 32'd1);
    check("t4a_rec", 32'(ctrl_state), 32'd5);
    check("t4a_frc", 32'(dl_forcerxmode), 32'd3);
    check("t4a_ready", 32'({phy_ready, datapath_resetn}), 32'd0);
    act = 2'b00;
    run_recover("t4a");

    // Startup with a single stopstate drop after 100 cycles.
    stop = 1'b1;
    tick(100);
    stop = 1'b0;
    tick();
    check("t2_state", 32'(ctrl_state), 32'd1);
    run_startup("t2");

    // Skew one cycle too late.
    act = 2'b11; syn = 2'b01;
    tick();
    syn = 2'b00;
    tick(3);
    check("t3b_sync", 32'(ctrl_state), 32'd3);
    check("t3b_noerr", 32'(err_skew), 32'd0);
    syn = 2'b10;
    tick();
    check("t3b_err", 32'(err_skew), 32'd1);
    check("t3b_rec", 32'(ctrl_state), 32'd5);
    check("t3b_frc", 32'(dl_forcerxmode), 32'd3);
    syn = 2'b00; act = 2'b00;
    run_recover("t3b");
`ifdef CSI_PHY_STATS_EN
    check("st_rec2", 32'(recover_count), 32'd2);
    check("st_skew1", 32'(skew_err_count), 32'd1);
`endif

    // Disable mid-RX.
    run_startup("t5");
    act = 2'b11; syn = 2'b11;
    tick();
    syn = 2'b00;
    tick(5);
    check("t5_rx", 32'(ctrl_state), 32'd4);
    en = 1'b0;
    tick();
    check("t5_off", 32'(ctrl_state), 32'd0);
    check("t5_en", 32'({cl_enable, dl_enable}), 32'd0);
    check("t5_ready", 32'({phy_ready, datapath_resetn}), 32'd0);
    act = 2'b00;
    en = 1'b1;
    tick();
    check("t5_restart", 32'(ctrl_state), 32'd1);
`ifdef CSI_PHY_STATS_EN
    check("st_hold_rec", 32'(recover_count), 32'd2);
    check("st_hold_skew", 32'(skew_err_count), 32'd1);
`endif

    // All lanes drop HS before sync completes, then async reset during RECOVER.
    run_startup("t6");
    act = 2'b11; syn = 2'b01;
    tick();
    act = 2'b00; syn = 2'b00;
    tick();
    check("t6_err", 32'(err_skew), 32'd1);
    check("t6_rec", 32'(ctrl_state), 32'd5);
`ifdef CSI_PHY_STATS_EN
    check("st_rec3", 32'(recover_count), 32'd3);
    check("st_skew2", 32'(skew_err_count), 32'd2);
`endif
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_state", 32'(ctrl_state), 32'd0);
    check("t6_arst_frc", 32'(dl_forcerxmode), 32'd0);
    check("t6_arst_en", 32'({cl_enable, dl_enable}), 32'd0);
`ifdef CSI_PHY_STATS_EN
    check("st_arst", 32'({recover_count, skew_err_count}), 32'd0);
`endif
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
